// File: rtl/ata_pkg.sv
// ATA PIO timing constants, FSM state encoding and ns-to-cycle helpers.
// Latency: n/a (types, constants and elaboration-time functions only).
// Backpressure: n/a.
package ata_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_IORDY,
    ST_DONE,
    ST_RECOVER
  } state_t;

  localparam int NUM_MODES = 5;

  // ATA PIO modes 0..4, in ns: address setup, strobe width, recovery (t0-t1-t2)
  localparam int T1_NS   [NUM_MODES] = '{70, 50, 30, 30, 25};
  localparam int T2_NS   [NUM_MODES] = '{165, 125, 100, 80, 70};
  localparam int TREC_NS [NUM_MODES] = '{365, 208, 110, 70, 25};

  // Round up to whole clocks, never below one cycle, saturate at the 8-bit counter range
  function automatic logic [7:0] ns_to_cycles(input int ns, input int period);
    int c;
    c = (ns + period - 1) / period;
    if (c < 1) c = 1;
    if (c > 255) c = 255;
    return 8'(c);
  endfunction

  // Modes above 4 run at mode 4 timing
  function automatic logic [2:0] mode_clamp(input logic [2:0] m);
    return (m > 3'd4) ? 3'd4 : m;
  endfunction

endpackage

// File: rtl/ata_sync2.sv
// Two-flop synchroniser for an asynchronous level input, selectable reset value.
// Latency: 2 clk edges from input change to q.
// Backpressure: none.
module ata_sync2 #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async input through two flops to resolve metastability
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ata_wait_gen.sv
// WAIT stretch generator enforcing ATA PIO t1/t2/recovery and IORDY for Gayle IDE cycles.
// Latency: WAIT released T1+T2+1 edges after req is sampled (T1+T2 without IORDY phase).
// Backpressure: WAIT low holds the decoder's DTACK/strobes; only AS rising ends a cycle.
module ata_wait_gen
  import ata_pkg::*;
#(
  parameter int CLK_PERIOD_NS = 20,
  parameter bit IORDY_EN      = 1'b1,
  parameter int IORDY_TIMEOUT = 63
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       AS,
  input  logic       ACCESS,
  input  logic [2:0] PIO_MODE,
  input  logic       IORDY,
  output logic       WAIT,
  output logic       BUSY,
  output logic       TIMEOUT
);

  // Per-mode cycle counts, resolved at elaboration
  localparam logic [7:0] T1_CYC [NUM_MODES] = '{
    ns_to_cycles(T1_NS[0], CLK_PERIOD_NS), ns_to_cycles(T1_NS[1], CLK_PERIOD_NS),
    ns_to_cycles(T1_NS[2], CLK_PERIOD_NS), ns_to_cycles(T1_NS[3], CLK_PERIOD_NS),
    ns_to_cycles(T1_NS[4], CLK_PERIOD_NS)};
  localparam logic [7:0] T2_CYC [NUM_MODES] = '{
    ns_to_cycles(T2_NS[0], CLK_PERIOD_NS), ns_to_cycles(T2_NS[1], CLK_PERIOD_NS),
    ns_to_cycles(T2_NS[2], CLK_PERIOD_NS), ns_to_cycles(T2_NS[3], CLK_PERIOD_NS),
    ns_to_cycles(T2_NS[4], CLK_PERIOD_NS)};
  localparam logic [7:0] TREC_CYC [NUM_MODES] = '{
    ns_to_cycles(TREC_NS[0], CLK_PERIOD_NS), ns_to_cycles(TREC_NS[1], CLK_PERIOD_NS),
    ns_to_cycles(TREC_NS[2], CLK_PERIOD_NS), ns_to_cycles(TREC_NS[3], CLK_PERIOD_NS),
    ns_to_cycles(TREC_NS[4], CLK_PERIOD_NS)};

  // Timeout counter is 8 bits, so the load value saturates at 255
  localparam int         TO_CYC  = (IORDY_TIMEOUT < 1)   ? 1 :
                                   (IORDY_TIMEOUT > 256) ? 256 : IORDY_TIMEOUT;
  localparam logic [7:0] TO_LOAD = 8'(TO_CYC - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] tocnt;
  logic [2:0] mode;
  logic       req;
  logic       iordy_s;
  logic [2:0] mode_new;
  logic [7:0] t1_new;
  logic [7:0] t2_cur;
  logic [7:0] trec_cur;

  assign req = ~AS & ~ACCESS;

  // WAIT is decoded straight from the bus so it drops in the same cycle the access decodes
  assign WAIT = ~(req & (state != ST_DONE));
  assign BUSY = (state != ST_IDLE);

  ata_sync2 #(.RESET_VAL(1'b1)) u_iordy_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (IORDY),
    .q   (iordy_s)
  );

  // Setup count comes from the live mode (cycle start); strobe/recovery use the latched mode
  always_comb begin
    mode_new = mode_clamp(PIO_MODE);
    t1_new   = T1_CYC[mode_new];
    t2_cur   = T2_CYC[mode];
    trec_cur = TREC_CYC[mode];
  end

  // Cycle sequencer: setup -> strobe -> IORDY -> done -> recovery, AS rising aborts to recovery
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= ST_IDLE;
      cnt     <= 8'd0;
      tocnt   <= 8'd0;
      mode    <= 3'd0;
      TIMEOUT <= 1'b0;
    end else begin
      TIMEOUT <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            state <= ST_SETUP;
            mode  <= mode_new;
            cnt   <= t1_new - 8'd1;
          end
        end
        ST_SETUP: begin
          if (AS) begin
            state <= ST_RECOVER;
            cnt   <= trec_cur - 8'd1;
          end else if (cnt == 8'd0) begin
            state <= ST_STROBE;
            cnt   <= t2_cur - 8'd1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_STROBE: begin
          if (AS) begin
            state <= ST_RECOVER;
            cnt   <= trec_cur - 8'd1;
          end else if (cnt == 8'd0) begin
            if (IORDY_EN) begin
              state <= ST_IORDY;
              tocnt <= TO_LOAD;
            end else begin
              state <= ST_DONE;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_IORDY: begin
          // An abort takes priority so a dropped cycle never reports a timeout
          if (AS) begin
            state <= ST_RECOVER;
            cnt   <= trec_cur - 8'd1;
          end else if (iordy_s) begin
            state <= ST_DONE;
          end else if (tocnt == 8'd0) begin
            state   <= ST_DONE;
            TIMEOUT <= 1'b1;
          end else begin
            tocnt <= tocnt - 8'd1;
          end
        end
        ST_DONE: begin
          if (AS) begin
            state <= ST_RECOVER;
            cnt   <= trec_cur - 8'd1;
          end
        end
        ST_RECOVER: begin
          // A request queued during recovery starts its own setup without passing IDLE
          if (cnt == 8'd0) begin
            if (req) begin
              state <= ST_SETUP;
              mode  <= mode_new;
              cnt   <= t1_new - 8'd1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
